// File: rtl/test_osc_pkg.sv
// Shared mode encoding and LED pattern rules for the oscillator/LED bring-up block.
package test_osc_pkg;

    typedef enum logic [1:0] {
        MODE_COUNT  = 2'd0,
        MODE_ROTATE = 2'd1,
        MODE_BLINK  = 2'd2,
        MODE_OFF    = 2'd3
    } mode_t;

    localparam logic [2:0] INIT_COUNT  = 3'b000;
    localparam logic [2:0] INIT_ROTATE = 3'b001;
    localparam logic [2:0] INIT_BLINK  = 3'b111;
    localparam logic [2:0] INIT_OFF    = 3'b000;

    function automatic mode_t mode_advance(mode_t cur);
        mode_t nxt;
        case (cur)
            MODE_COUNT:  nxt = MODE_ROTATE;
            MODE_ROTATE: nxt = MODE_BLINK;
            MODE_BLINK:  nxt = MODE_OFF;
            default:     nxt = MODE_COUNT;
        endcase
        return nxt;
    endfunction

    function automatic logic [2:0] init_pattern(mode_t m);
        logic [2:0] pat;
        case (m)
            MODE_COUNT:  pat = INIT_COUNT;
            MODE_ROTATE: pat = INIT_ROTATE;
            MODE_BLINK:  pat = INIT_BLINK;
            default:     pat = INIT_OFF;
        endcase
        return pat;
    endfunction

    function automatic logic [2:0] step_pattern(mode_t m, logic [2:0] cur);
        logic [2:0] pat;
        case (m)
            MODE_COUNT:  pat = cur + 3'd1;
            MODE_ROTATE: pat = {cur[1:0], cur[2]};
            MODE_BLINK:  pat = ~cur;
            default:     pat = 3'b000;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/test_osc_led_btn_debounce.sv
// Two-flop synchroniser, hold-time debouncer and press (1->0) pulse for an active-low button.
module btn_debounce #(
    parameter int DebounceLen = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic button,
    output logic press
);

    localparam int CntW = (DebounceLen > 1) ? $clog2(DebounceLen) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(DebounceLen - 1);

    logic            sync_ff;
    logic            sync_btn;
    logic            db_level;
    logic [CntW-1:0] cnt;

    // Released (1) is the safe reset level so a button held through reset still yields one press.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_ff  <= 1'b1;
            sync_btn <= 1'b1;
            db_level <= 1'b1;
            cnt      <= '0;
            press    <= 1'b0;
        end else begin
            sync_ff  <= button;
            sync_btn <= sync_ff;
            press    <= 1'b0;
            if (sync_btn == db_level) begin
                cnt <= '0;
            end else if (cnt == CntLast) begin
                db_level <= sync_btn;
                cnt      <= '0;
                press    <= ~sync_btn;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/test_osc_led.sv
// Board bring-up: prescaled step tick drives a 3-bit LED pattern; a debounced button cycles modes.
// mode | meaning: COUNT binary count, ROTATE walking one, BLINK all-invert, OFF dark
module test_osc_led
    import test_osc_pkg::*;
#(
    parameter int OscF        = 50_000_000,
    parameter int DebounceLen = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       button,
    output logic [2:0] led
);

    localparam int PreW = $clog2(OscF);
    localparam logic [PreW-1:0] PreLast = PreW'(OscF - 1);

    mode_t            mode;
    logic [PreW-1:0]  prescaler;
    logic             tick;
    logic             press;

    btn_debounce #(
        .DebounceLen (DebounceLen)
    ) u_btn (
        .clk    (clk),
        .rst    (rst),
        .button (button),
        .press  (press)
    );

    assign tick = (prescaler == PreLast);

    // A press restarts the step period so the new pattern is shown for a full step.
    always_ff @(posedge clk) begin
        if (rst) begin
            mode      <= MODE_COUNT;
            prescaler <= '0;
            led       <= 3'b000;
        end else if (press) begin
            mode      <= mode_advance(mode);
            prescaler <= '0;
            led       <= init_pattern(mode_advance(mode));
        end else begin
            if (tick) begin
                prescaler <= '0;
                led       <= step_pattern(mode, led);
            end else begin
                prescaler <= prescaler + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_test_osc_led.sv
// Directed bench for test_osc_led with OscF=5, DebounceLen=4; expected values traced by hand.
module tb_test_osc_led;

    logic       clk;
    logic       rst;
    logic       button;
    logic [2:0] led;

    int checks = 0;
    int errors = 0;

    test_osc_led #(
        .OscF        (5),
        .DebounceLen (4)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .button (button),
        .led    (led)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst    = 1'b1;
        button = 1'b1;
        step(3);
        checks++;
        if (led !== 3'b000) begin
            errors++; $display("FAIL reset_led got %b exp 000", led);
        end
        checks++;
        if (dut.mode !== 2'd0) begin
            errors++; $display("FAIL reset_mode got %0d exp 0", dut.mode);
        end
        checks++;
        if (dut.prescaler !== 3'd0) begin
            errors++; $display("FAIL reset_prescaler got %0d exp 0", dut.prescaler);
        end
        checks++;
        if (dut.u_btn.db_level !== 1'b1) begin
            errors++; $display("FAIL reset_db_level got %b exp 1", dut.u_btn.db_level);
        end
        rst = 1'b0;
    endtask

    task automatic test_count_wrap;
        logic [2:0] exp;
        step(4);
        checks++;
        if (led !== 3'b000) begin
            errors++; $display("FAIL count_before_first_tick got %b exp 000", led);
        end
        step(1);
        checks++;
        if (led !== 3'b001) begin
            errors++; $display("FAIL count_first_tick got %b exp 001", led);
        end
        for (int i = 2; i <= 8; i++) begin
            exp = 3'(i);
            step(5);
            checks++;
            if (led !== exp) begin
                errors++; $display("FAIL count_step%0d got %b exp %b", i, led, exp);
            end
        end
    endtask

    task automatic do_press(input logic [1:0] m_old, input logic [1:0] m_new,
                            input logic [2:0] init, input logic [2:0] s1,
                            input logic [2:0] s2, input logic [2:0] s3);
        button = 1'b0;
        step(5);
        checks++;
        if (dut.press !== 1'b0) begin
            errors++; $display("FAIL press_early to mode %0d got %b exp 0", m_new, dut.press);
        end
        step(1);
        checks++;
        if (dut.press !== 1'b1 || dut.mode !== m_old) begin
            errors++;
            $display("FAIL press_pulse to mode %0d got press=%b mode=%0d exp press=1 mode=%0d",
                     m_new, dut.press, dut.mode, m_old);
        end
        step(1);
        checks++;
        if (dut.mode !== m_new || led !== init || dut.press !== 1'b0) begin
            errors++;
            $display("FAIL press_load got mode=%0d led=%b press=%b exp mode=%0d led=%b press=0",
                     dut.mode, led, dut.press, m_new, init);
        end
        step(3);
        button = 1'b1;
        step(2);
        checks++;
        if (led !== s1) begin
            errors++; $display("FAIL mode%0d_step1 got %b exp %b", m_new, led, s1);
        end
        step(5);
        checks++;
        if (led !== s2) begin
            errors++; $display("FAIL mode%0d_step2 got %b exp %b", m_new, led, s2);
        end
        step(5);
        checks++;
        if (led !== s3) begin
            errors++; $display("FAIL mode%0d_step3 got %b exp %b", m_new, led, s3);
        end
        step(8);
        checks++;
        if (dut.mode !== m_new) begin
            errors++; $display("FAIL release_no_event got mode=%0d exp %0d", dut.mode, m_new);
        end
    endtask

    task automatic test_mode_cycle;
        do_press(2'd0, 2'd1, 3'b001, 3'b010, 3'b100, 3'b001);
        do_press(2'd1, 2'd2, 3'b111, 3'b000, 3'b111, 3'b000);
        do_press(2'd2, 2'd3, 3'b000, 3'b000, 3'b000, 3'b000);
        do_press(2'd3, 2'd0, 3'b000, 3'b001, 3'b010, 3'b011);
    endtask

    task automatic test_glitch;
        // entry: mode 0, led 100, prescaler 3
        button = 1'b0;
        step(1);
        checks++;
        if (led !== 3'b100) begin
            errors++; $display("FAIL glitch_pre got %b exp 100", led);
        end
        step(1);
        button = 1'b1;
        checks++;
        if (led !== 3'b101) begin
            errors++; $display("FAIL glitch_t1 got %b exp 101", led);
        end
        step(5);
        checks++;
        if (led !== 3'b110) begin
            errors++; $display("FAIL glitch_t2 got %b exp 110", led);
        end
        step(5);
        checks++;
        if (led !== 3'b111) begin
            errors++; $display("FAIL glitch_t3 got %b exp 111", led);
        end
        step(5);
        checks++;
        if (led !== 3'b000 || dut.mode !== 2'd0) begin
            errors++; $display("FAIL glitch_wrap got led=%b mode=%0d exp led=000 mode=0", led, dut.mode);
        end
    endtask

    task automatic test_press_on_tick;
        step(3);
        checks++;
        if (dut.prescaler !== 3'd3) begin
            errors++; $display("FAIL coincide_align got %0d exp 3", dut.prescaler);
        end
        button = 1'b0;
        step(2);
        checks++;
        if (led !== 3'b001) begin
            errors++; $display("FAIL coincide_pre_tick got %b exp 001", led);
        end
        step(4);
        checks++;
        if (dut.press !== 1'b1 || dut.prescaler !== 3'd4) begin
            errors++;
            $display("FAIL coincide_pulse got press=%b pre=%0d exp press=1 pre=4", dut.press, dut.prescaler);
        end
        step(1);
        checks++;
        if (dut.mode !== 2'd1 || led !== 3'b001) begin
            errors++; $display("FAIL coincide_load got mode=%0d led=%b exp mode=1 led=001", dut.mode, led);
        end
        step(4);
        checks++;
        if (led !== 3'b001) begin
            errors++; $display("FAIL coincide_hold got %b exp 001", led);
        end
        step(1);
        checks++;
        if (led !== 3'b010) begin
            errors++; $display("FAIL coincide_next got %b exp 010", led);
        end
        step(20);
        checks++;
        if (dut.mode !== 2'd1 || led !== 3'b100) begin
            errors++; $display("FAIL held_one_press got mode=%0d led=%b exp mode=1 led=100", dut.mode, led);
        end
    endtask

    task automatic test_reset_held;
        rst = 1'b1;
        step(1);
        checks++;
        if (led !== 3'b000 || dut.mode !== 2'd0 || dut.u_btn.db_level !== 1'b1) begin
            errors++;
            $display("FAIL midrun_reset got led=%b mode=%0d db=%b exp led=000 mode=0 db=1",
                     led, dut.mode, dut.u_btn.db_level);
        end
        rst = 1'b0;
        step(5);
        checks++;
        if (led !== 3'b001 || dut.mode !== 2'd0 || dut.press !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_tick got led=%b mode=%0d press=%b exp led=001 mode=0 press=0",
                     led, dut.mode, dut.press);
        end
        step(1);
        checks++;
        if (dut.press !== 1'b1) begin
            errors++; $display("FAIL post_reset_pulse got %b exp 1", dut.press);
        end
        step(1);
        checks++;
        if (dut.mode !== 2'd1 || led !== 3'b001) begin
            errors++;
            $display("FAIL post_reset_press got mode=%0d led=%b exp mode=1 led=001", dut.mode, led);
        end
        button = 1'b1;
        step(10);
    endtask

    initial begin
        rst    = 1'b1;
        button = 1'b1;
        test_reset;
        test_count_wrap;
        test_mode_cycle;
        test_glitch;
        test_press_on_tick;
        test_reset_held;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/test_osc_led.md
Name: test_osc_led

Overview:
- Board bring-up block: divides the system clock into a slow step tick and drives a 3-bit LED pattern from it.
- A single active-low push button, synchronised and debounced, cycles through four display modes.
- Used as a top-level sanity check that the oscillator, button and LEDs work. Instantiated directly under the board top.

Parameters:
- OscF, 50_000_000, clk cycles per pattern step (the clock frequency in Hz gives a 1 Hz step). Legal range is ≥2; benches use 5.
- DebounceLen, 4, consecutive clk cycles the synchronised button must hold a new level before it is accepted. Legal range is ≥1.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst  input  1  synchronous, active-high reset.
- button  input  1  push button, active low (0 = pressed), asynchronous to clk.
- led  output  3  LED pattern, registered, active high.

Behaviour:
- One clock domain. Reset is synchronous and active-high, sampled on the rising clk edge, and takes priority over everything else.
- Reset values:
  - led = 3'b000
  - mode = 0
  - prescaler = 0
  - both synchroniser flops = 1 (released)
  - debounced level = 1
  - debounce counter = 0
- Synchroniser: two flops on button, giving sync_btn.
- Debouncer:
  - If sync_btn equals the debounced level, the counter clears to 0.
  - Otherwise the counter increments.
  - When the counter reaches DebounceLen-1 while still differing, the debounced level takes sync_btn and the counter clears on that same edge.
- Press event: a one-cycle pulse on the edge where the debounced level goes 1→0. Release produces no event.
- Press latency: button low before edge N gives the press pulse registered at edge N+2+DebounceLen-1. Glitches shorter than DebounceLen cycles are ignored.
- Mode register (2 bits): each press event advances it by 1, wrapping 3→0.
- On the press edge:
  - mode takes its new value.
  - The prescaler clears to 0.
  - led loads the initial value of the new mode.
- Modes, listed as initial value then step rule:
  - 0 binary count: 000, then led+1 mod 8 (111→000).
  - 1 rotate: 001, then rotate left (001→010→100→001).
  - 2 blink: 111, then bitwise invert (111↔000).
  - 3 off: 000, stays 000.
- Prescaler:
  - Counts 0..OscF-1 and wraps to 0.
  - Tick is asserted in the cycle where prescaler == OscF-1.
  - led advances one step on each tick edge, so the period is exactly OscF cycles.
- Simultaneous press and tick: the press wins. led loads the initial value and no step is applied.
- A held button produces exactly one press. The next press requires a debounced release first.
- Reset mid-operation returns all state to the reset values on the next edge, including a press in progress.

Decomposition:
- Shared package test_osc_pkg holds:
  - the mode enumeration (MODE_COUNT, MODE_ROTATE, MODE_BLINK, MODE_OFF)
  - the initial-pattern constants per mode
- One sub-module, btn_debounce, containing the 2-flop synchroniser, the debounce counter and the falling-edge press pulse. It takes DebounceLen as a parameter.
- The prescaler and pattern logic stay in the top module.

Test Plan (OscF=5, DebounceLen=4, 10 ns clk):
- Reset held 3 cycles, button=1 -> led=000 and mode 0. After release, led steps 001, 010, … every 5 cycles and wraps 111→000 after 40 cycles.
- Button low for 10 cycles then high -> exactly one press, 5 cycles after button falls. led becomes 001, then 010, 100, 001 every 5 cycles.
- Three further presses, each 10 cycles low and 20 high -> blink mode 111/000 toggling every 5 cycles, then off (000 constant), then back to mode 0 starting at 000.
- Button low for 2 cycles (glitch) -> no mode change and led sequence undisturbed.
- Press timed so the press pulse coincides with prescaler == 4 -> led loads the new mode's initial value and the next step occurs 5 cycles later.
- Assert rst while in rotate mode with the button held -> led=000 and mode 0 next edge. After rst drops with the button still low, one press is registered once the debounce completes (debounced level was reset to 1).
